sp_fifo_ctrl: RTL and testbench
===============================

Name: sp_fifo_ctrl

Overview:
- FIFO controller that sequences a single-port RAM (1-cycle write, 1-cycle read latency) as FIFO storage; the RAM is instantiated next to this block, not inside it.
- Only one RAM access is allowed per cycle, so the block arbitrates between push-side writes and pop-side prefetch reads.
- Read data lands in a 2-entry output skid buffer so the consumer can stall without losing in-flight reads.
- Push and pop sides use valid/ready handshakes.

Parameters:
- WIDTH, 16, data width in bits.
- SIZE, 32, RAM depth; power of 2, >= 2.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- push_valid  in  1  producer has data.
- push_ready  out  1  push accepted this cycle when push_valid && push_ready.
- push_data  in  WIDTH  data to enqueue.
- pop_valid  out  1  pop_data valid.
- pop_ready  in  1  consumer takes pop_data this cycle.
- pop_data  out  WIDTH  head of FIFO.
- count  out  $clog2(SIZE)+2  total entries held: RAM + in-flight read + skid buffer; max SIZE+2.
- ram_wen  out  1  RAM write enable.
- ram_ren  out  1  RAM read enable.
- ram_waddr  out  $clog2(SIZE)  write address.
- ram_raddr  out  $clog2(SIZE)  read address.
- ram_wdata  out  WIDTH  write data (= push_data).
- ram_rdata  in  WIDTH  RAM read data, valid the cycle after ram_ren.

Behaviour:
- State:
  - wptr, rptr: $clog2(SIZE) bits, wrap naturally.
  - ram_cnt: 0..SIZE.
  - rd_inflight: 1 bit.
  - obuf: 2 entries plus ob_cnt 0..2.
  - last_grant: 1 bit; 0 = last grant was write.
- Reset: all state 0 (asynchronous). While rst_n = 0, force push_ready = 0. Reset values: pop_valid = 0, count = 0, ram_wen = 0, ram_ren = 0, addresses 0.
- Candidates each cycle:
  - W = push_valid && ram_cnt < SIZE.
  - R = ram_cnt > 0 && (ob_cnt + rd_inflight) < 2.
- Grant:
  - Only W: write. Only R: read.
  - Both: per the optional feature.
  - At most one of ram_wen/ram_ren is high in any cycle.
- push_ready = write granted. It depends combinationally on push_valid; this is permitted.
- On write: ram_wen = 1, ram_waddr = wptr, ram_wdata = push_data, wptr++, ram_cnt++.
- On read: ram_ren = 1, ram_raddr = rptr, rptr++, ram_cnt--, rd_inflight set for the next cycle.
- rd_inflight = 1: capture ram_rdata into obuf tail at the clock edge; ob_cnt++.
- Pop:
  - pop_valid = ob_cnt > 0; pop_data = obuf head (registered, no combinational path from ram_rdata).
  - pop_valid && pop_ready: head dequeued.
  - Capture and dequeue in the same cycle: ob_cnt unchanged, order preserved.
- Latency: push accepted in cycle T into an empty FIFO -> read issued T+1 -> captured at end of T+2 -> pop_valid high in T+3.
- No bypass path from push_data to pop_data.
- Full: ram_cnt = SIZE -> push_ready = 0. The skid buffer can still hold 2 more, so total capacity is SIZE+2.
- Empty: ram_cnt = 0 -> no reads; pop_valid drops after the last obuf entry is popped.
- Simultaneous push and pop: count changes by (push accepted) - (pop taken).
- Wrap: pointers roll SIZE-1 -> 0. Full/empty are decided by ram_cnt, never by pointer compare.
- Throughput: sustained streaming alternates W/R, giving 1 word per 2 cycles. This is accepted for a single-port RAM.
- Reset mid-operation: contents are discarded and all pointers and counters return to 0. RAM contents are not cleared.

Optional Feature:
- Macro: SP_FIFO_RR_ARB_EN.
- Defined: when W and R are both candidates, grant the side opposite to last_grant. last_grant updates on every grant.
- Undefined: when W and R are both candidates, write always wins. Reads proceed only when no write candidate exists. last_grant is not implemented.

Test Plan:
- Reset: rst_n low for 2 cycles during active push/pop traffic -> same cycle: pop_valid = 0, count = 0, ram_wen = ram_ren = 0, push_ready = 0. After release, first push lands at ram_waddr 0.
- Latency: empty FIFO, pop_ready = 1, push 16'hA5A5 in cycle 0 -> ram_wen cycle 0, ram_ren cycle 1, pop_valid = 1 with pop_data = 16'hA5A5 in cycle 3, count back to 0 in cycle 4.
- Fill (SIZE = 32), pop_ready = 0, push_valid held with data 0..33 -> exactly 34 words accepted, then push_ready = 0 and count = 34. Set pop_ready = 1 -> pops 0..33 in order, count ends at 0.
- Contention with SP_FIFO_RR_ARB_EN, FIFO preloaded with 4 words, push_valid = 1, pop_ready = 1 -> ram_wen/ram_ren strictly alternate every cycle. Without the macro -> ram_wen every cycle until ram_cnt = 32, reads only afterwards.
- Wrap/order: 200 pushes of an incrementing pattern with random push_valid/pop_ready at 50% -> output sequence identical to input, pointers wrap at least 6 times, ram_wen && ram_ren never both 1, count matches the scoreboard every cycle.

Source files
------------

// File: rtl/sp_fifo_ctrl.sv
// FIFO controller around an external single-port RAM, with a 2-entry output skid buffer.
// Define SP_FIFO_RR_ARB_EN for round-robin write/read arbitration; otherwise writes have priority.
module sp_fifo_ctrl #(
    parameter int WIDTH = 16,
    parameter int SIZE  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_valid,
    output logic                       push_ready,
    input  logic [WIDTH-1:0]           push_data,
    output logic                       pop_valid,
    input  logic                       pop_ready,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(SIZE)+1:0]    count,
    output logic                       ram_wen,
    output logic                       ram_ren,
    output logic [$clog2(SIZE)-1:0]    ram_waddr,
    output logic [$clog2(SIZE)-1:0]    ram_raddr,
    output logic [WIDTH-1:0]           ram_wdata,
    input  logic [WIDTH-1:0]           ram_rdata
);
    localparam int AW = $clog2(SIZE);
    localparam int CW = AW + 2;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(SIZE);

    logic [AW-1:0]    wptr_reg, rptr_reg;
    logic [AW:0]      ram_cnt_reg, ram_cnt_next;
    logic             rd_inflight_reg;
    logic             ob_head_reg;
    logic [1:0]       ob_cnt_reg, ob_cnt_next;
    logic [1:0]       ob_fill;
    logic             ob_tail;
    logic [WIDTH-1:0] ob_entry [2];

    logic w_cand, r_cand, wr_grant, rd_grant, pop_take;

    // Count in-flight reads as occupied so a capture always has a free slot.
    assign ob_fill = ob_cnt_reg + {1'b0, rd_inflight_reg};
    assign w_cand  = rst_n && push_valid && (ram_cnt_reg != FULL_CNT);
    assign r_cand  = rst_n && (ram_cnt_reg != '0) && (ob_fill < 2'd2);

`ifdef SP_FIFO_RR_ARB_EN
    logic last_grant_reg;  // 0 = last grant was a write, 1 = read

    always_comb begin
        wr_grant = w_cand && (!r_cand || last_grant_reg);
        rd_grant = r_cand && (!w_cand || !last_grant_reg);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_reg <= 1'b0;
        end else if (wr_grant) begin
            last_grant_reg <= 1'b0;
        end else if (rd_grant) begin
            last_grant_reg <= 1'b1;
        end
    end
`else
    always_comb begin
        wr_grant = w_cand;
        rd_grant = r_cand && !w_cand;
    end
`endif

    assign push_ready = wr_grant;
    assign ram_wen    = wr_grant;
    assign ram_ren    = rd_grant;
    assign ram_waddr  = wptr_reg;
    assign ram_raddr  = rptr_reg;
    assign ram_wdata  = push_data;

    assign pop_valid = (ob_cnt_reg != 2'd0);
    assign pop_data  = ob_entry[ob_head_reg];
    assign pop_take  = pop_valid && pop_ready;
    assign count     = CW'(ram_cnt_reg) + CW'(rd_inflight_reg) + CW'(ob_cnt_reg);

    // A capture only happens with at most one entry held, so tail = head + ob_cnt mod 2.
    assign ob_tail = ob_head_reg ^ ob_cnt_reg[0];

    always_comb begin
        ram_cnt_next = ram_cnt_reg;
        if (wr_grant) begin
            ram_cnt_next = ram_cnt_reg + 1'b1;
        end else if (rd_grant) begin
            ram_cnt_next = ram_cnt_reg - 1'b1;
        end
        ob_cnt_next = ob_cnt_reg + {1'b0, rd_inflight_reg} - {1'b0, pop_take};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_reg        <= '0;
            rptr_reg        <= '0;
            ram_cnt_reg     <= '0;
            rd_inflight_reg <= 1'b0;
            ob_head_reg     <= 1'b0;
            ob_cnt_reg      <= 2'd0;
        end else begin
            if (wr_grant) begin
                wptr_reg <= wptr_reg + 1'b1;
            end
            if (rd_grant) begin
                rptr_reg <= rptr_reg + 1'b1;
            end
            ram_cnt_reg     <= ram_cnt_next;
            rd_inflight_reg <= rd_grant;
            ob_cnt_reg      <= ob_cnt_next;
            if (pop_take) begin
                ob_head_reg <= ~ob_head_reg;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gen_obuf
            logic [WIDTH-1:0] entry_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    entry_reg <= '0;
                end else if (rd_inflight_reg && (ob_tail == 1'(gi))) begin
                    entry_reg <= ram_rdata;
                end
            end

            assign ob_entry[gi] = entry_reg;
        end
    endgenerate

endmodule

// File: tb/tb_sp_fifo_ctrl.sv
// Bench for sp_fifo_ctrl: a behavioural single-port RAM plus a scoreboard of pushed words
// checked against every popped word, with directed latency/fill/contention/reset/wrap cases.
module tb_sp_fifo_ctrl;
    localparam int WIDTH = 16;
    localparam int SIZE  = 32;
    localparam int AW    = $clog2(SIZE);
    localparam int CW    = AW + 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             push_valid, push_ready, pop_valid, pop_ready;
    logic [WIDTH-1:0] push_data, pop_data;
    logic [CW-1:0]    count;
    logic             ram_wen, ram_ren;
    logic [AW-1:0]    ram_waddr, ram_raddr;
    logic [WIDTH-1:0] ram_wdata, ram_rdata;

    logic [WIDTH-1:0] ram_mem [SIZE];

    int n_tests = 0;
    int n_fail  = 0;
    int model_cnt = 0;
    int wraps = 0;
    int n_acc = 0;
    logic [WIDTH-1:0] sb [$];
    logic [WIDTH-1:0] exp_word;
    logic [AW-1:0]    prev_waddr = '0;
    logic             have_prev = 1'b0;
    logic             prev_wen;

    always #5 clk = ~clk;

    sp_fifo_ctrl #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .push_data  (push_data),
        .pop_valid  (pop_valid),
        .pop_ready  (pop_ready),
        .pop_data   (pop_data),
        .count      (count),
        .ram_wen    (ram_wen),
        .ram_ren    (ram_ren),
        .ram_waddr  (ram_waddr),
        .ram_raddr  (ram_raddr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    // Single-port RAM model: 1-cycle write, registered read.
    always @(posedge clk) begin
        if (ram_wen) ram_mem[ram_waddr] <= ram_wdata;
        if (ram_ren) ram_rdata <= ram_mem[ram_raddr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Monitor: count/exclusivity every cycle, scoreboard on every handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            model_cnt = 0;
            have_prev = 1'b0;
            check("reset_count", 32'(count), 32'd0);
        end else begin
            check("count", 32'(count), 32'(model_cnt));
            check("one_access", 32'(ram_wen && ram_ren), 32'd0);
            if (push_valid && push_ready) begin
                sb.push_back(push_data);
                model_cnt++;
            end
            if (pop_valid && pop_ready) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL pop_unexpected: got %0h, expected no pop", pop_data);
                end else begin
                    exp_word = sb.pop_front();
                    check("pop_data", 32'(pop_data), 32'(exp_word));
                end
                model_cnt--;
            end
            if (ram_wen) begin
                if (have_prev && prev_waddr == AW'(SIZE - 1) && ram_waddr == '0) wraps++;
                prev_waddr = ram_waddr;
                have_prev  = 1'b1;
            end
        end
    end

    task automatic drain(input string name);
        int c;
        push_valid = 1'b0;
        pop_ready  = 1'b1;
        c = 0;
        sample();
        while (count != '0 && c < 400) begin
            sample();
            c++;
        end
        check(name, 32'(count), 32'd0);
        check({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        push_valid = 1'b0;
        pop_ready  = 1'b0;
        push_data  = '0;
        repeat (2) @(posedge clk);
        sample();
        check("init_pop_valid", 32'(pop_valid), 32'd0);
        check("init_wen_ren", 32'({ram_wen, ram_ren}), 32'd0);
        check("init_push_ready", 32'(push_ready), 32'd0);
        tick();
        rst_n = 1'b1;

        // Latency through an empty FIFO.
        tick();
        push_valid = 1'b1;
        push_data  = 16'hA5A5;
        pop_ready  = 1'b1;
        sample();
        check("lat_c0_wen", 32'(ram_wen), 32'd1);
        check("lat_c0_waddr", 32'(ram_waddr), 32'd0);
        check("lat_c0_ren", 32'(ram_ren), 32'd0);
        tick();
        push_valid = 1'b0;
        sample();
        check("lat_c1_ren", 32'(ram_ren), 32'd1);
        check("lat_c1_raddr", 32'(ram_raddr), 32'd0);
        tick();
        sample();
        check("lat_c2_pop_valid", 32'(pop_valid), 32'd0);
        tick();
        sample();
        check("lat_c3_pop_valid", 32'(pop_valid), 32'd1);
        check("lat_c3_pop_data", 32'(pop_data), 32'hA5A5);
        tick();
        sample();
        check("lat_c4_count", 32'(count), 32'd0);
        check("lat_c4_pop_valid", 32'(pop_valid), 32'd0);

        // Fill to SIZE+2 with the consumer stalled.
        tick();
        pop_ready  = 1'b0;
        push_valid = 1'b1;
        n_acc      = 0;
        push_data  = '0;
        for (int c = 0; c < 100; c++) begin
            sample();
            if (push_ready) n_acc++;
            tick();
            push_data = WIDTH'(n_acc);
        end
        sample();
        check("fill_accepted", 32'(n_acc), 32'd34);
        check("fill_push_ready", 32'(push_ready), 32'd0);
        check("fill_count", 32'(count), 32'd34);
        tick();
        drain("fill_drain");

        // Preload 4 words, then push and pop together.
        tick();
        pop_ready  = 1'b0;
        push_valid = 1'b1;
        n_acc      = 0;
        push_data  = 16'h2000;
        for (int c = 0; c < 40 && n_acc < 4; c++) begin
            sample();
            if (push_ready) n_acc++;
            tick();
            push_data = 16'h2000 + WIDTH'(n_acc);
        end
        push_valid = 1'b0;
        repeat (4) tick();
        push_valid = 1'b1;
        pop_ready  = 1'b1;
`ifdef SP_FIFO_RR_ARB_EN
        prev_wen = 1'b0;
        for (int k = 0; k < 16; k++) begin
            sample();
            check("rr_one_access", 32'(ram_wen ^ ram_ren), 32'd1);
            if (k > 0) check("rr_alternate", 32'(ram_wen), 32'(!prev_wen));
            prev_wen = ram_wen;
            if (push_ready) n_acc++;
            tick();
            push_data = 16'h2000 + WIDTH'(n_acc);
        end
`else
        // ram_cnt is 2 here (two words prefetched into the skid buffer): 30 writes to fill.
        for (int k = 0; k < 30; k++) begin
            sample();
            check("wprio_wen", 32'({ram_wen, ram_ren}), 32'b10);
            if (push_ready) n_acc++;
            tick();
            push_data = 16'h2000 + WIDTH'(n_acc);
        end
        sample();
        check("wprio_read_when_full", 32'({ram_wen, ram_ren}), 32'b01);
        tick();
`endif

        // Asynchronous reset in the middle of traffic.
        rst_n = 1'b0;
        #1;
        check("rst_pop_valid", 32'(pop_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_wen_ren", 32'({ram_wen, ram_ren}), 32'd0);
        check("rst_push_ready", 32'(push_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        push_valid = 1'b0;
        pop_ready  = 1'b0;
        rst_n      = 1'b1;
        tick();
        push_valid = 1'b1;
        push_data  = 16'h3333;
        sample();
        check("post_rst_wen", 32'(ram_wen), 32'd1);
        check("post_rst_waddr", 32'(ram_waddr), 32'd0);
        tick();
        drain("post_rst_drain");

        // Random handshakes over several pointer wraps.
        wraps = 0;
        n_acc = 0;
        for (int c = 0; c < 5000 && n_acc < 200; c++) begin
            tick();
            push_valid = 1'($urandom_range(0, 1));
            push_data  = 16'h4000 + WIDTH'(n_acc);
            pop_ready  = 1'($urandom_range(0, 1));
            sample();
            if (push_valid && push_ready) n_acc++;
        end
        tick();
        drain("wrap_drain");
        check("wrap_accepted", 32'(n_acc), 32'd200);
        check("wrap_count_ge6", 32'(wraps >= 6), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
